// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and flush controller for a five-stage pipeline. It decides, every
//   cycle, whether the PC and IF/ID advance, whether IF/ID is replaced by a NOP,
//   and whether ID/EXE takes the ID instruction or a bubble. It handles
//   load-use stalls, taken branches resolved in EXE, jumps resolved in ID and
//   the halt instruction. Two saturating counters record stall cycles and
//   flush events.
//
//   State updates happen on the falling clock edge, matching the pipeline
//   registers that this block steers.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (legal 1..3)
//   CNT_W              width of the performance counters
//
// Ports
//   clock              pipeline clock (falling-edge active)
//   reset              asynchronous, active-high reset
//   id_rs, id_rt       source registers of the instruction in ID
//   id_uses_rt         ID instruction reads rt as a source
//   id_jump            ID instruction is j / jal / jr
//   id_halt            ID instruction is halt / syscall
//   exe_memRead        EXE instruction is a load
//   exe_rt             destination register of the EXE load
//   exe_branch_taken   EXE beq is taken
//   pc_write           PC load enable
//   pc_sel_branch      PC takes the EXE branch target
//   if_id_write        IF/ID load enable
//   if_id_flush        IF/ID loads a NOP
//   id_exe_write       3'b111 passes ID contents, 3'b000 inserts a bubble
//   stall_cycles       saturating count of bubble cycles caused by load-use
//   flush_events       saturating count of branch and jump flushes
//   halted             pipeline frozen by halt
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_halt,
  input  logic             exe_memRead,
  input  logic [4:0]       exe_rt,
  input  logic             exe_branch_taken,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [2:0]       id_exe_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             halted
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Value loaded into the down-counter when a load-use hazard is detected:
  // the detecting cycle is itself the first bubble.
  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] stall_left;
  logic [1:0] stall_left_nxt;
  logic       run_en;
  logic       load_use;
  logic       cnt_stall;
  logic       cnt_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A load into r0 never produces a value, so it can never cause a hazard.
  assign load_use = exe_memRead && (exe_rt != 5'd0) &&
                    ((exe_rt == id_rs) || (id_uses_rt && (exe_rt == id_rt)));

  assign halted = (state == HALT);

  // Mealy decode. run_en is low from reset until the first falling edge after
  // reset is released; in that window every control output stays inactive and
  // nothing is counted.
  always_comb begin
    pc_write       = 1'b0;
    pc_sel_branch  = 1'b0;
    if_id_write    = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_write   = 3'b000;
    state_nxt      = state;
    stall_left_nxt = stall_left;
    cnt_stall      = 1'b0;
    cnt_flush      = 1'b0;
    if (run_en) begin
      case (state)
        RUN: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_exe_write = 3'b111;
          if (exe_branch_taken) begin
            // Squash the wrong-path instructions in IF and ID.
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_exe_write  = 3'b000;
            cnt_flush     = 1'b1;
          end else if (load_use) begin
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            id_exe_write   = 3'b000;
            cnt_stall      = 1'b1;
            stall_left_nxt = STALL_RELOAD;
            state_nxt      = (STALL_RELOAD != 2'd0) ? STALL : RUN;
          end else if (id_halt) begin
            // The halt itself proceeds to EXE; younger fetches are discarded.
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            state_nxt   = HALT;
          end else if (id_jump) begin
            if_id_flush = 1'b1;
            cnt_flush   = 1'b1;
          end
        end
        STALL: begin
          // EXE holds a bubble here, so branch/jump/halt inputs are not valid.
          cnt_stall      = 1'b1;
          stall_left_nxt = stall_left - 2'd1;
          if (stall_left <= 2'd1) begin
            state_nxt = RUN;
          end
        end
        HALT: begin
          state_nxt = HALT;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      stall_left   <= 2'd0;
      run_en       <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      run_en     <= 1'b1;
      state      <= state_nxt;
      stall_left <= stall_left_nxt;
      if (cnt_stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      if (cnt_flush) begin
        flush_events <= sat_inc(flush_events);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Two instances (LOAD_STALL_CYCLES = 1 and 3) share one input stimulus.
//   A behavioural model tracks "pending bubbles", "halted" and counter values
//   per instance and predicts the control outputs and counters each cycle.
//   Inputs change just after the rising edge; outputs are sampled before the
//   falling (active) edge and counters just after it.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, exe_rt = '0;
  logic       id_uses_rt = 1'b0, id_jump = 1'b0, id_halt = 1'b0;
  logic       exe_memRead = 1'b0, exe_branch_taken = 1'b0;

  logic        pw1, ps1, iw1, if1, h1, pw3, ps3, iw3, if3, h3;
  logic [2:0]  ie1, ie3;
  logic [15:0] sc1, fe1, sc3, fe3;
  logic [7:0]  pk1, pk3;

  assign pk1 = {pw1, ps1, iw1, if1, ie1, h1};
  assign pk3 = {pw3, ps3, iw3, if3, ie3, h3};

  always #5 clock = ~clock;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .id_halt(id_halt),
    .exe_memRead(exe_memRead), .exe_rt(exe_rt), .exe_branch_taken(exe_branch_taken),
    .pc_write(pw1), .pc_sel_branch(ps1), .if_id_write(iw1), .if_id_flush(if1),
    .id_exe_write(ie1), .stall_cycles(sc1), .flush_events(fe1), .halted(h1));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .id_halt(id_halt),
    .exe_memRead(exe_memRead), .exe_rt(exe_rt), .exe_branch_taken(exe_branch_taken),
    .pc_write(pw3), .pc_sel_branch(ps3), .if_id_write(iw3), .if_id_flush(if3),
    .id_exe_write(ie3), .stall_cycles(sc3), .flush_events(fe3), .halted(h3));

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state, index 0 -> dut1, index 1 -> dut3
  int lsc[2]     = '{1, 3};
  int m_pend[2]  = '{0, 0};
  int m_stall[2] = '{0, 0};
  int m_flush[2] = '{0, 0};
  bit m_halt[2]  = '{0, 0};
  bit m_arm[2]   = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    return exe_memRead && (exe_rt != 5'd0) &&
           ((exe_rt == id_rs) || (id_uses_rt && (exe_rt == id_rt)));
  endfunction

  // Expected {pc_write, pc_sel_branch, if_id_write, if_id_flush, id_exe_write, halted}
  function automatic logic [7:0] exp_pk(input int k);
    if (!m_arm[k])        return 8'b0000_000_0;
    if (m_halt[k])        return 8'b0000_000_1;
    if (m_pend[k] > 0)    return 8'b0000_000_0;
    if (exe_branch_taken) return 8'b1111_000_0;
    if (hazard())         return 8'b0000_000_0;
    if (id_halt)          return 8'b0011_111_0;
    if (id_jump)          return 8'b1011_111_0;
    return 8'b1010_111_0;
  endfunction

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_step(input int k);
    if (!m_arm[k]) m_arm[k] = 1'b1;
    else if (m_halt[k]) begin end
    else if (m_pend[k] > 0) begin
      m_pend[k]--;
      m_stall[k] = sat(m_stall[k]);
    end else if (exe_branch_taken) m_flush[k] = sat(m_flush[k]);
    else if (hazard()) begin
      m_stall[k] = sat(m_stall[k]);
      m_pend[k]  = lsc[k] - 1;
    end else if (id_halt) m_halt[k] = 1'b1;
    else if (id_jump) m_flush[k] = sat(m_flush[k]);
  endtask

  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                     input bit ur, input bit mr, input bit br, input bit h, input bit j,
                     input bit do_chk);
    @(posedge clock); #1;
    id_rs = rs; id_rt = rt; exe_rt = ert; id_uses_rt = ur;
    exe_memRead = mr; exe_branch_taken = br; id_halt = h; id_jump = j;
    #1;
    if (do_chk) begin
      chk("out_lsc1", pk1, exp_pk(0));
      chk("out_lsc3", pk3, exp_pk(1));
    end
    @(negedge clock);
    model_step(0);
    model_step(1);
    #1;
    if (do_chk) begin
      chk("stall_lsc1", sc1, m_stall[0]);
      chk("stall_lsc3", sc3, m_stall[1]);
      chk("flush_lsc1", fe1, m_flush[0]);
      chk("flush_lsc3", fe3, m_flush[1]);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    id_rs = '0; id_rt = '0; exe_rt = '0; id_uses_rt = 0;
    exe_memRead = 0; exe_branch_taken = 0; id_halt = 0; id_jump = 0;
    #1;
    chk("rst_out_lsc1", pk1, 8'h00);
    chk("rst_out_lsc3", pk3, 8'h00);
    chk("rst_cnt_lsc1", {sc1, fe1}, 32'h0);
    chk("rst_cnt_lsc3", {sc3, fe3}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      m_arm[k] = 0; m_halt[k] = 0; m_pend[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
    @(negedge clock); #1;
    chk("rst_hold_lsc1", pk1, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rel_out_lsc1", pk1, 8'h00);
    chk("rel_out_lsc3", pk3, 8'h00);
    @(negedge clock);
    model_step(0);
    model_step(1);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int halt_run;
    logic [4:0] rs, rt, ert;

    do_reset();

    // Load-use on r8: one bubble for LSC=1, three for LSC=3
    cyc(5'd8, 5'd0, 5'd8, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 1);
    chk("req034_stall", sc1, 32'd1);
    chk("req035_stall", sc3, 32'd3);

    // Branch together with load-use: branch wins, nothing stalls
    do_reset();
    cyc(5'd8, 5'd0, 5'd8, 0, 1, 1, 0, 0, 1);
    chk("req036_flush", fe1, 32'd1);
    chk("req036_stall", sc3, 32'd0);

    // Load into r0 never stalls
    cyc(5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 1);
    chk("req037_nostall", sc1, 32'd0);

    // Halt freezes until reset
    cyc(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 1);
    chk("req038_halted", h1, 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      chk("req038_pcw", pw1, 32'd0);
    end
    do_reset();

    // Randomised traffic, small register set to provoke hazards
    halt_run = 0;
    for (int i = 0; i < 600; i++) begin
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      ert = 5'($urandom_range(0, 3));
      cyc(rs, rt, ert, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 20), 1);
      if (m_halt[0] || m_halt[1]) halt_run++;
      if (halt_run >= 4) begin
        do_reset();
        halt_run = 0;
      end
    end

    // Flush counter saturation
    do_reset();
    for (int i = 0; i < 65535; i++) cyc(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0);
    chk("sat_pre_lsc1", fe1, 32'hFFFF);
    cyc(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1);
    chk("req039_sat_lsc1", fe1, 32'hFFFF);
    chk("req039_sat_lsc3", fe3, 32'hFFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1, legal 1-3: bubbles inserted per load-use hazard.
REQ-002 Parameter CNT_W, default 16: width of performance counters.
REQ-003 clock  input  1  pipeline clock; all state updates on the falling edge, matching the pipeline registers.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_rs, id_rt  input  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rt  input  1  ID instruction reads rt as a source (R-type, beq, sw).
REQ-007 id_jump  input  1  ID instruction is j, jal or jr.
REQ-008 id_halt  input  1  ID instruction is the halt/syscall opcode.
REQ-009 exe_memRead, exe_rt  input  1, 5  EXE-stage load flag and its destination register.
REQ-010 exe_branch_taken  input  1  EXE-stage beq with zero flag set.
REQ-011 pc_write  output  1  PC register load enable.
REQ-012 pc_sel_branch  output  1  PC takes the EXE branch target.
REQ-013 if_id_write, if_id_flush  output  1 each  IF/ID hold control; flush loads a NOP.
REQ-014 id_exe_write  output  3  ID/EXE control: 3'b111 passes ID contents; 3'b000 inserts a bubble.
REQ-015 stall_cycles, flush_events  output  CNT_W each  saturating performance counters.
REQ-016 halted  output  1  pipeline frozen by halt.

Function
REQ-017 The FSM SHALL have the states RUN, STALL and HALT.
REQ-018 load_use SHALL be exe_memRead & (exe_rt!=0) & ((exe_rt==id_rs) | (id_uses_rt & (exe_rt==id_rt))).
REQ-019 Outputs SHALL be combinational from state and current inputs (Mealy); the default in RUN is pc_write=1, if_id_write=1, if_id_flush=0, pc_sel_branch=0, id_exe_write=3'b111.
REQ-020 RUN priority SHALL be exe_branch_taken > load_use > id_halt > id_jump.
REQ-021 RUN with exe_branch_taken: pc_write=1, pc_sel_branch=1, if_id_flush=1, id_exe_write=3'b000; flush_events += 1; next state RUN.
REQ-022 RUN with load_use: pc_write=0, if_id_write=0, id_exe_write=3'b000; stall_cycles += 1; a down-counter is loaded with LOAD_STALL_CYCLES-1; next state is STALL if that value is nonzero, else RUN.
REQ-023 STALL: pc_write=0, if_id_write=0, id_exe_write=3'b000; stall_cycles += 1; the counter decrements; exit to RUN on the edge where the counter goes from 1 to 0.
REQ-024 STALL SHALL ignore exe_branch_taken, id_jump and id_halt; EXE holds a bubble, so none is valid.
REQ-025 RUN with id_halt and no higher-priority event: the halt passes to EXE (id_exe_write=3'b111) with pc_write=0 and if_id_flush=1; next state HALT.
REQ-026 HALT: pc_write=0, if_id_write=0, id_exe_write=3'b000, halted=1; only reset exits HALT.
REQ-027 RUN with id_jump only: pc_write=1, if_id_flush=1, id_exe_write=3'b111; flush_events += 1.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 A load-use hazard on register 0 SHALL never stall.
REQ-030 Branch and load-use asserted together: the branch wins and no stall is counted.

Reset
REQ-031 While reset=1: state=RUN, down-counter=0, stall_cycles=0, flush_events=0, halted=0, pc_write=0, if_id_write=0, if_id_flush=0, pc_sel_branch=0, id_exe_write=3'b000.
REQ-032 Reset asserted mid-STALL or in HALT SHALL return the block to RUN immediately, without waiting for a clock edge.
REQ-033 After reset is released, the RUN default outputs SHALL apply from the next falling edge.

Verification
REQ-034 LOAD_STALL_CYCLES=1, exe_memRead=1, exe_rt=8, id_rs=8 -> one cycle with pc_write=0 and id_exe_write=000, then RUN; stall_cycles=1.
REQ-035 LOAD_STALL_CYCLES=3, same hazard -> three consecutive bubble cycles, state RUN-STALL-STALL-RUN; stall_cycles=3.
REQ-036 exe_branch_taken=1 together with load_use -> pc_sel_branch=1, if_id_flush=1, id_exe_write=000; flush_events=1, stall_cycles=0.
REQ-037 exe_rt=0, id_rs=0, exe_memRead=1 -> no stall; id_exe_write=111.
REQ-038 id_halt=1 -> halted=1 from the next edge; pc_write stays 0 for 10 cycles; reset pulse -> halted=0 asynchronously.
REQ-039 Preload flush_events to all-ones via 65535 jumps, then one more jump -> flush_events stays 16'hFFFF.
